stopwatch_timer_core: RTL

Parametrised successor to the board stopwatch datapath: a BCD time-of-run engine supporting count-up stopwatch and count-down timer modes, with a configurable tick base, a lap-capture FIFO, and expiry signalling. It sits between the debounce/edge-detect front end (single-cycle clean pulses in) and the seven-segment scan driver (packed BCD digits out). It owns no display logic.

---
 rtl/stopwatch_pkg.sv | 94 +++++++++
 rtl/stopwatch_timer_core_lap_fifo.sv | 73 +++++++
 rtl/stopwatch_timer_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | stopwatch_pkg: shared types, constants and BCD helpers for the stopwatch core
// | Revision: 1.0
// +----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t hh;
    bcd_pair_t mm;
    bcd_pair_t ss;
    bcd_pair_t cc;
  } sw_time_t;

  localparam int unsigned c_max_sexagesimal = 59;
  localparam int unsigned c_max_digit       = 9;

  function automatic bcd_pair_t to_bcd_pair(input int unsigned n);
    bcd_pair_t p;
    p.tens  = bcd_digit_t'((n / 10) % 10);
    p.units = bcd_digit_t'(n % 10);
    return p;
  endfunction

  // Two-digit BCD increment, wrapping max_v -> 00.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input bcd_pair_t max_v);
    bcd_pair_t r;
    r = v;
    if (v == max_v) begin
      r = '0;
    end else if (v.units == bcd_digit_t'(c_max_digit)) begin
      r.tens  = v.tens + 4'd1;
      r.units = '0;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  // Two-digit BCD decrement, wrapping 00 -> max_v.
  function automatic bcd_pair_t bcd_dec(input bcd_pair_t v, input bcd_pair_t max_v);
    bcd_pair_t r;
    r = v;
    if (v == '0) begin
      r = max_v;
    end else if (v.units == '0) begin
      r.tens  = v.tens - 4'd1;
      r.units = bcd_digit_t'(c_max_digit);
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

  // One tick of the time-of-run value with ripple carry (up) or borrow (down).
  function automatic sw_time_t time_step(input sw_time_t t, input logic down,
                                         input bcd_pair_t cc_max, input bcd_pair_t hh_max);
    sw_time_t  r;
    bcd_pair_t m59;
    logic      c;
    m59  = to_bcd_pair(c_max_sexagesimal);
    r    = t;
    r.cc = down ? bcd_dec(t.cc, cc_max) : bcd_inc(t.cc, cc_max);
    c    = down ? (t.cc == '0) : (t.cc == cc_max);
    if (c) begin
      r.ss = down ? bcd_dec(t.ss, m59) : bcd_inc(t.ss, m59);
      c    = down ? (t.ss == '0) : (t.ss == m59);
    end
    if (c) begin
      r.mm = down ? bcd_dec(t.mm, m59) : bcd_inc(t.mm, m59);
      c    = down ? (t.mm == '0) : (t.mm == m59);
    end
    if (c) begin
      r.hh = down ? bcd_dec(t.hh, hh_max) : bcd_inc(t.hh, hh_max);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_timer_core_lap_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | lap_fifo: show-ahead synchronous FIFO for lap captures
// | Revision: 1.0
// +----------------------------------------------------------------------------
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             push_drop
);

  localparam int unsigned c_aw = $clog2(DEPTH);

  logic [c_aw:0]      wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic               empty;
  logic               wr_en;
  logic               rd_en;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]) && (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]);
    rd_en     = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    wr_en     = push && (!full || pop);
    push_drop = push && full && !pop && !flush;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[c_aw-1:0]] = push_data;
        wr_ptr_d                  = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
    valid = !empty;
    head  = empty ? '0 : mem_q[rd_ptr_q[c_aw-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | stopwatch_timer_core: BCD stopwatch / countdown timer with lap capture FIFO
// | Revision: 1.0
// +----------------------------------------------------------------------------
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned HOUR_MAX  = 23,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        lap_rd,
  input  logic        set_min,
  input  logic        set_hour,
  input  logic        countdown,
  output logic [31:0] time_bcd,
  output logic        running,
  output logic        expired,
  output logic        done,
  output logic [31:0] lap_bcd,
  output logic        lap_valid,
  output logic        lap_full,
  output logic        lap_ovf
);

  localparam int unsigned           c_div      = CLK_HZ / TICK_HZ;
  localparam int unsigned           c_div_w    = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(c_div - 1);
  localparam bcd_pair_t             c_cc_max   = to_bcd_pair(TICK_HZ - 1);
  localparam bcd_pair_t             c_hh_max   = to_bcd_pair(HOUR_MAX);
  localparam bcd_pair_t             c_mm_max   = to_bcd_pair(c_max_sexagesimal);

  sw_state_t            state_q, state_d;
  sw_time_t             time_q, time_d;
  logic [c_div_w-1:0]   div_q, div_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 lap_ovf_q, lap_ovf_d;

  logic                 tick;
  logic                 mode_change;
  logic                 time_is_zero;
  sw_time_t             time_stepped;
  logic                 lap_push;
  logic                 lap_drop;

  always_comb begin
    tick         = (state_q == ST_RUN) && (div_q == c_div_last);
    mode_change  = (countdown != mode_q);
    time_is_zero = (time_q == '0);
    time_stepped = time_step(time_q, mode_q, c_cc_max, c_hh_max);

    state_d = state_q;
    time_d  = time_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    div_d   = '0;

    if (clear) begin
      state_d = ST_IDLE;
      time_d  = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (mode_q && (time_stepped == '0)) begin
              state_d = ST_EXPIRED;
              time_d  = '0;
              done_d  = 1'b1;
            end else begin
              time_d = time_stepped;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_EXPIRED: begin
          // stop outranks start even though stop itself does nothing here
          if (!stop && start) begin
            state_d = ST_IDLE;
            time_d  = '0;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (mode_change) begin
            mode_d  = countdown;
            time_d  = '0;
            state_d = ST_IDLE;
          end else if (stop) begin
            state_d = state_q;
          end else if (start) begin
            if (!(mode_q && time_is_zero)) begin
              state_d = ST_RUN;
            end
          end else begin
            if (set_min) begin
              time_d.mm = bcd_inc(time_q.mm, c_mm_max);
            end
            if (set_hour) begin
              time_d.hh = bcd_inc(time_q.hh, c_hh_max);
            end
          end
        end
      endcase
    end

    lap_push  = lap && (state_q == ST_RUN) && !clear;
    lap_ovf_d = clear ? 1'b0 : (lap_ovf_q | (lap_push && lap_drop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      div_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      lap_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      lap_ovf_q <= lap_ovf_d;
    end
  end

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (32)
  ) u_lap_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (lap_push),
    .pop       (lap_rd),
    .push_data (time_q),
    .head      (lap_bcd),
    .valid     (lap_valid),
    .full      (lap_full),
    .push_drop (lap_drop)
  );

  assign time_bcd = time_q;
  assign running  = (state_q == ST_RUN);
  assign expired  = (state_q == ST_EXPIRED);
  assign done     = done_q;
  assign lap_ovf  = lap_ovf_q;

endmodule
`default_nettype wire
